// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: presents program words one at a time over a valid/ack
// handshake, tracks load/data pairs, and stops on HALT_OP or the last address.
module instr_sequencer #(
  parameter int unsigned IW      = 11,
  parameter int unsigned AW      = 4,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [AW-1:0] last_addr,
  input  logic          start,
  input  logic          instr_ack,
  output logic [IW-1:0] INSTRUCTION,
  output logic          instr_valid,
  output logic          data_word,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          err
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [2:0]  LOAD_OP = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] last_q;
  logic          expect_data;
  logic [IW-1:0] fetch_word_c;
  logic          fetch_halt_c;
  logic          issue_load_c;

  assign fetch_word_c = mem[pc];
  // A data word is never decoded, even if its top bits look like HALT_OP.
  assign fetch_halt_c = !expect_data && (fetch_word_c[IW-1 -: 3] == HALT_OP);
  assign issue_load_c = !data_word && (INSTRUCTION[IW-1 -: 3] == LOAD_OP);

  // Program memory is writable only while no run is in progress.
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE || state == HALT)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      INSTRUCTION <= '0;
      instr_valid <= 1'b0;
      data_word   <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
      expect_data <= 1'b0;
      last_q      <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc          <= '0;
            expect_data <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            last_q      <= last_addr;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          INSTRUCTION <= fetch_word_c;
          data_word   <= expect_data;
          if (fetch_halt_c) begin
            halted <= 1'b1;
            busy   <= 1'b0;
            state  <= HALT;
          end else begin
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ack) begin
            instr_valid <= 1'b0;
            expect_data <= issue_load_c;
            if (pc == last_q) begin
              halted <= 1'b1;
              busy   <= 1'b0;
              err    <= issue_load_c;
              state  <= HALT;
            end else begin
              pc    <= pc + AW'(1);
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with hand-computed expected words.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [10:0] prog_data;
  logic [3:0]  last_addr;
  logic        start;
  logic        instr_ack;
  logic [10:0] INSTRUCTION;
  logic        instr_valid;
  logic        data_word;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;
  logic        err;

  int total = 0;
  int bad   = 0;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .last_addr(last_addr), .start(start),
    .instr_ack(instr_ack), .INSTRUCTION(INSTRUCTION), .instr_valid(instr_valid),
    .data_word(data_word), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] a, input logic [10:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic kick(input logic [3:0] last);
    last_addr = last; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for a word, check it, stall the ack, then accept it.
  task automatic issue_word(input logic [10:0] w, input logic [3:0] a,
                            input logic dw, input int stall);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check("valid_timeout", 32'(instr_valid), 32'd1);
    check("instr", 32'(INSTRUCTION), 32'(w));
    check("pc", 32'(pc), 32'(a));
    check("data_word", 32'(data_word), 32'(dw));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", 32'(INSTRUCTION), 32'(w));
      check("stall_pc", 32'(pc), 32'(a));
    end
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
  endtask

  initial begin
    logic [10:0] p3 [5];
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    last_addr = '0; start = 1'b0; instr_ack = 1'b0;

    // Reset and idle
    tick();
    reset = 1'b0;
    check("rst_instr", 32'(INSTRUCTION), 32'd0);
    check("rst_outs", 32'({instr_valid, data_word, busy, halted, err}), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    for (int i = 0; i < 10; i++) begin
      instr_ack = 1'b1;
      tick();
      check("idle_valid", 32'(instr_valid), 32'd0);
    end
    instr_ack = 1'b0;

    // Load pair with exact latency checks
    prog(4'd0, 11'h016);
    prog(4'd1, 11'h007);
    kick(4'd1);
    check("fetch_valid", 32'(instr_valid), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    tick();
    check("lat_start_valid", 32'(instr_valid), 32'd1);
    issue_word(11'h016, 4'd0, 1'b0, 0);
    check("ack_clears_valid", 32'(instr_valid), 32'd0);
    tick();
    check("lat_ack_valid", 32'(instr_valid), 32'd1);
    issue_word(11'h007, 4'd1, 1'b1, 0);
    check("pair_halted", 32'(halted), 32'd1);
    check("pair_err", 32'(err), 32'd0);
    check("pair_busy", 32'(busy), 32'd0);

    // Full program with a 5-cycle stall on word 2
    p3[0] = 11'h026; p3[1] = 11'h008; p3[2] = 11'h132; p3[3] = 11'h231; p3[4] = 11'h312;
    for (int i = 0; i < 5; i++) prog(4'(i), p3[i]);
    kick(4'd4);
    check("restart_clears_halt", 32'(halted), 32'd0);
    for (int i = 0; i < 5; i++) issue_word(p3[i], 4'(i), i == 1, (i == 2) ? 5 : 0);
    check("prog_halted", 32'(halted), 32'd1);
    check("prog_err", 32'(err), 32'd0);
    check("prog_pc", 32'(pc), 32'd4);

    // HALT opcode at word 0
    prog(4'd0, 11'h700);
    kick(4'd3);
    tick();
    check("halt_op_halted", 32'(halted), 32'd1);
    check("halt_op_instr", 32'(INSTRUCTION), 32'h700);
    for (int i = 0; i < 4; i++) begin
      check("halt_op_valid", 32'(instr_valid), 32'd0);
      tick();
    end

    // HALT-looking data word after a load is issued as data
    prog(4'd0, 11'h026);
    prog(4'd1, 11'h7FF);
    prog(4'd2, 11'h132);
    kick(4'd2);
    issue_word(11'h026, 4'd0, 1'b0, 0);
    issue_word(11'h7FF, 4'd1, 1'b1, 0);
    check("data_halt_no_stop", 32'(halted), 32'd0);
    issue_word(11'h132, 4'd2, 1'b0, 0);
    check("data_halt_end", 32'({halted, err}), 32'b10);

    // Truncated load
    kick(4'd0);
    issue_word(11'h026, 4'd0, 1'b0, 0);
    check("trunc_halted", 32'(halted), 32'd1);
    check("trunc_err", 32'(err), 32'd1);

    // Write, start ignored during ISSUE; reset mid-run
    prog(4'd0, 11'h132);
    kick(4'd3);
    tick();
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 11'h231; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    check("issue_hold_valid", 32'(instr_valid), 32'd1);
    check("issue_hold_instr", 32'(INSTRUCTION), 32'h132);
    check("issue_start_pc", 32'(pc), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_outs", 32'({instr_valid, data_word, busy, halted, err}), 32'd0);
    check("midrst_instr", 32'(INSTRUCTION), 32'd0);
    kick(4'd0);
    issue_word(11'h132, 4'd0, 1'b0, 0);
    check("single_word_halt", 32'({halted, err}), 32'b10);

    // Write and start in the same cycle
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 11'h312;
    kick(4'd0);
    prog_we = 1'b0;
    issue_word(11'h312, 4'd0, 1'b0, 0);

    // last_addr at maximum: sixteen words, no wrap
    for (int i = 0; i < 16; i++) prog(4'(i), 11'h100 + 11'(i));
    kick(4'd15);
    for (int i = 0; i < 16; i++) issue_word(11'h100 + 11'(i), 4'(i), 1'b0, 0);
    check("max_halted", 32'(halted), 32'd1);
    check("max_pc", 32'(pc), 32'd15);
    tick();
    check("max_no_wrap", 32'(instr_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
